boton_peatonal: RTL and testbench

//  - Upstream stage of the intersection controller (calle): conditions the two raw pedestrian push-buttons

---
 rtl/boton_peatonal_pkg.sv | 33 +++
 rtl/boton_peatonal_antirrebote.sv | 60 ++++++
 rtl/boton_peatonal.sv | 88 ++++++++
 tb/tb_boton_peatonal.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boton_peatonal_pkg.sv
// Shared encodings for the pedestrian-button stage: light codes seen from calle
// and the per-crossing request FSM states, plus the FSM next-state function.
package boton_peatonal_pkg;

  typedef enum logic [1:0] {
    ROJO     = 2'b00,
    AMARILLO = 2'b01,
    VERDE    = 2'b10,
    ILEGAL   = 2'b11
  } luz_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } estado_t;

  // Next state of one crossing's request FSM. An illegal state code falls back to IDLE;
  // an illegal light code (2'b11) is simply "not ROJO", so the request stays pending.
  function automatic estado_t siguiente(input estado_t    est,
                                        input logic       rise,
                                        input logic       level,
                                        input logic [1:0] luz);
    siguiente = IDLE;
    case (est)
      IDLE:    siguiente = rise ? PENDING : IDLE;
      PENDING: siguiente = (luz == ROJO) ? SERVED : PENDING;
      SERVED:  siguiente = level ? SERVED : IDLE;
      default: siguiente = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/boton_peatonal_antirrebote.sv
// antirrebote: two-flop synchroniser plus debounce counter for one raw button.
// level_out flips after DEB_CYCLES consecutive synchronised samples that differ from it;
// rise_pulse is a one-cycle (enabled-cycle) pulse on an accepted press.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [1:0]    vld;
  logic [CW-1:0] cnt;

  // Synchroniser runs regardless of enb; vld marks when sync[1] holds a real sample
  // rather than its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      vld  <= '0;
    end else begin
      sync <= {sync[0], raw_in};
      vld  <= {vld[0], 1'b1};
    end
  end

  // Debounce: count consecutive samples differing from the tracked level, flip at DEB_CYCLES.
  // The level starts high so a button held through reset must be released (and debounced low)
  // before its next press can raise a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_out  <= 1'b1;
      cnt        <= '0;
      rise_pulse <= 1'b0;
    end else if (enb) begin
      rise_pulse <= 1'b0;
      if (vld[1]) begin
        if (sync[1] != level_out) begin
          if (cnt == LAST) begin
            level_out  <= sync[1];
            cnt        <= '0;
            rise_pulse <= sync[1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/boton_peatonal.sv
// boton_peatonal: conditions the two pedestrian buttons into the a_peatonal / b_peatonal
// request levels consumed by calle. Optional served-request counters are built when
// BOTON_PEATONAL_CONTADOR_EN is defined.
module boton_peatonal
  import boton_peatonal_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic [1:0]       semaforo_a,
  input  logic [1:0]       semaforo_b,
  output logic             a_peatonal,
  output logic             b_peatonal
`ifdef BOTON_PEATONAL_CONTADOR_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  logic    level_a, rise_a, level_b, rise_b;
  estado_t est_a, est_b, nxt_a, nxt_b;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .raw_in     (btn_a),
    .level_out  (level_a),
    .rise_pulse (rise_a)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .raw_in     (btn_b),
    .level_out  (level_b),
    .rise_pulse (rise_b)
  );

  // Next-state decode for both crossings.
  always_comb begin
    nxt_a = siguiente(est_a, rise_a, level_a, semaforo_a);
    nxt_b = siguiente(est_b, rise_b, level_b, semaforo_b);
  end

  // Crossing A request FSM with registered request output.
  always_ff @(posedge clk) begin
    if (reset) begin
      est_a      <= IDLE;
      a_peatonal <= 1'b0;
    end else if (enb) begin
      est_a      <= nxt_a;
      a_peatonal <= (nxt_a == PENDING);
    end
  end

  // Crossing B request FSM with registered request output.
  always_ff @(posedge clk) begin
    if (reset) begin
      est_b      <= IDLE;
      b_peatonal <= 1'b0;
    end else if (enb) begin
      est_b      <= nxt_b;
      b_peatonal <= (nxt_b == PENDING);
    end
  end

`ifdef BOTON_PEATONAL_CONTADOR_EN
  // Served-request counters: bump on each PENDING->SERVED transition, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (enb) begin
      if (est_a == PENDING && nxt_a == SERVED) cnt_a <= cnt_a + 1'b1;
      if (est_b == PENDING && nxt_b == SERVED) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_boton_peatonal.sv
// Directed self-checking bench for boton_peatonal (DEB_CYCLES=4, CNT_W=2).
module tb_boton_peatonal;

  localparam int unsigned DEB = 4;
  localparam int unsigned CW  = 2;
  localparam logic [1:0] L_ROJO  = 2'b00;
  localparam logic [1:0] L_VERDE = 2'b10;
  localparam logic [1:0] L_ILEG  = 2'b11;

  logic       clk = 1'b0;
  logic       reset, enb, btn_a, btn_b;
  logic [1:0] semaforo_a, semaforo_b;
  logic       a_peatonal, b_peatonal;
`ifdef BOTON_PEATONAL_CONTADOR_EN
  logic [CW-1:0] cnt_a, cnt_b;
  logic [CW-1:0] exp_cnt_a = '0;
  logic [CW-1:0] exp_cnt_b = '0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  boton_peatonal #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .semaforo_a (semaforo_a),
    .semaforo_b (semaforo_b),
    .a_peatonal (a_peatonal),
    .b_peatonal (b_peatonal)
`ifdef BOTON_PEATONAL_CONTADOR_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enb = 1'b1; btn_a = 1'b1; btn_b = 1'b1;
    semaforo_a = L_VERDE; semaforo_b = L_VERDE;
    tick(3);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL reset_a: got %b expected 0", a_peatonal); end
    tests++; if (b_peatonal !== 1'b0) begin fails++; $display("FAIL reset_b: got %b expected 0", b_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    tests++; if (cnt_a !== '0 || cnt_b !== '0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b); end
`endif
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      tests++;
      if (a_peatonal !== 1'b0 || b_peatonal !== 1'b0) begin
        fails++; $display("FAIL reset_held_btn cyc%0d: got a=%b b=%b expected 0 0", i, a_peatonal, b_peatonal);
      end
    end
    btn_a = 1'b0; btn_b = 1'b0;
    tick(10);
    tests++; if (a_peatonal !== 1'b0 || b_peatonal !== 1'b0) begin fails++; $display("FAIL reset_release: got a=%b b=%b expected 0 0", a_peatonal, b_peatonal); end
  endtask

  task automatic test_clean_press;
    btn_a = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      tests++;
      if (a_peatonal !== (i == 7)) begin fails++; $display("FAIL press_latency edge%0d: got %b expected %b", i, a_peatonal, (i == 7)); end
      tests++;
      if (b_peatonal !== 1'b0) begin fails++; $display("FAIL press_b_quiet edge%0d: got %b expected 0", i, b_peatonal); end
    end
    tick(5);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL press_hold_verde: got %b expected 1", a_peatonal); end
  endtask

  task automatic test_service;
    semaforo_a = L_ROJO;
    tick(1);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL serve_drop: got %b expected 0", a_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_a = 2'd1;
    tests++; if (cnt_a !== exp_cnt_a) begin fails++; $display("FAIL serve_cnt: got %0d expected %0d", cnt_a, exp_cnt_a); end
`endif
    semaforo_a = L_VERDE;
    tick(15);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL serve_held_no_rereq: got %b expected 0", a_peatonal); end
    btn_a = 1'b0;
    tick(8);
    btn_a = 1'b1;
    tick(6);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL repress_early: got %b expected 0", a_peatonal); end
    tick(1);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL repress_edge7: got %b expected 1", a_peatonal); end
    semaforo_a = L_ROJO;
    tick(1);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL repress_serve: got %b expected 0", a_peatonal); end
    btn_a = 1'b0; semaforo_a = L_VERDE;
    tick(8);
    // Light already red when the press is accepted: request visible for exactly one cycle.
    semaforo_a = L_ROJO; btn_a = 1'b1;
    tick(6);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL rojo_pre_early: got %b expected 0", a_peatonal); end
    tick(1);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL rojo_pre_one_cycle: got %b expected 1", a_peatonal); end
    tick(1);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL rojo_pre_drop: got %b expected 0", a_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_a = 2'd3;
    tests++; if (cnt_a !== exp_cnt_a) begin fails++; $display("FAIL rojo_pre_cnt: got %0d expected %0d", cnt_a, exp_cnt_a); end
`endif
    btn_a = 1'b0; semaforo_a = L_VERDE;
    tick(8);
  endtask

  task automatic test_illegal_light;
    semaforo_a = L_ILEG; btn_a = 1'b1;
    tick(7);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL illegal_assert: got %b expected 1", a_peatonal); end
    tick(10);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL illegal_stays_pending: got %b expected 1", a_peatonal); end
    semaforo_a = L_ROJO;
    tick(1);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL illegal_then_rojo: got %b expected 0", a_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_a = 2'd0;
    tests++; if (cnt_a !== exp_cnt_a) begin fails++; $display("FAIL illegal_cnt_wrap: got %0d expected %0d", cnt_a, exp_cnt_a); end
`endif
    btn_a = 1'b0; semaforo_a = L_VERDE;
    tick(8);
  endtask

  task automatic test_bounce;
    for (int c = 0; c < 10; c++) begin
      btn_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL bounce_hi c%0d k%0d: got %b expected 0", c, k, a_peatonal); end
      end
      btn_a = 1'b0;
      tick(1);
      tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL bounce_lo c%0d: got %b expected 0", c, a_peatonal); end
    end
    tick(8);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL bounce_after: got %b expected 0", a_peatonal); end
  endtask

  task automatic test_channel_b;
    btn_b = 1'b1;
    tick(7);
    tests++; if (b_peatonal !== 1'b1) begin fails++; $display("FAIL chan_b_assert: got %b expected 1", b_peatonal); end
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL chan_b_a_quiet: got %b expected 0", a_peatonal); end
    semaforo_a = L_ROJO;
    tick(3);
    tests++; if (b_peatonal !== 1'b1) begin fails++; $display("FAIL chan_b_ignores_light_a: got %b expected 1", b_peatonal); end
    semaforo_a = L_VERDE; semaforo_b = L_ROJO;
    tick(1);
    tests++; if (b_peatonal !== 1'b0) begin fails++; $display("FAIL chan_b_serve: got %b expected 0", b_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_b = 2'd1;
    tests++; if (cnt_b !== exp_cnt_b) begin fails++; $display("FAIL chan_b_cnt: got %0d expected %0d", cnt_b, exp_cnt_b); end
`endif
    btn_b = 1'b0; semaforo_b = L_VERDE;
    tick(8);
  endtask

  task automatic test_simultaneous_reset;
    btn_a = 1'b1; btn_b = 1'b1;
    tick(6);
    tests++; if (a_peatonal !== 1'b0 || b_peatonal !== 1'b0) begin fails++; $display("FAIL simul_early: got a=%b b=%b expected 0 0", a_peatonal, b_peatonal); end
    tick(1);
    tests++; if (a_peatonal !== 1'b1 || b_peatonal !== 1'b1) begin fails++; $display("FAIL simul_both: got a=%b b=%b expected 1 1", a_peatonal, b_peatonal); end
    reset = 1'b1;
    tick(1);
    tests++; if (a_peatonal !== 1'b0 || b_peatonal !== 1'b0) begin fails++; $display("FAIL simul_reset_drop: got a=%b b=%b expected 0 0", a_peatonal, b_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_a = '0; exp_cnt_b = '0;
    tests++; if (cnt_a !== exp_cnt_a || cnt_b !== exp_cnt_b) begin fails++; $display("FAIL simul_reset_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b); end
`endif
    reset = 1'b0;
    tick(20);
    tests++; if (a_peatonal !== 1'b0 || b_peatonal !== 1'b0) begin fails++; $display("FAIL simul_held_after_reset: got a=%b b=%b expected 0 0", a_peatonal, b_peatonal); end
    btn_a = 1'b0; btn_b = 1'b0;
    tick(10);
  endtask

  task automatic test_enb_freeze;
    btn_a = 1'b1;
    tick(3);
    enb = 1'b0;
    tick(10);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL enb_frozen: got %b expected 0", a_peatonal); end
    enb = 1'b1;
    tick(3);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL enb_edge16: got %b expected 0", a_peatonal); end
    tick(1);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL enb_edge17: got %b expected 1", a_peatonal); end
    enb = 1'b0; semaforo_a = L_ROJO;
    tick(3);
    tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL enb_hold_pending: got %b expected 1", a_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    tests++; if (cnt_a !== exp_cnt_a) begin fails++; $display("FAIL enb_hold_cnt: got %0d expected %0d", cnt_a, exp_cnt_a); end
`endif
    enb = 1'b1;
    tick(1);
    tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL enb_resume_serve: got %b expected 0", a_peatonal); end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    exp_cnt_a = 2'd1;
    tests++; if (cnt_a !== exp_cnt_a) begin fails++; $display("FAIL enb_resume_cnt: got %0d expected %0d", cnt_a, exp_cnt_a); end
`endif
    btn_a = 1'b0; semaforo_a = L_VERDE;
    tick(8);
  endtask

  task automatic test_back_to_back;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    for (int s = 1; s <= 5; s++) begin
      btn_a = 1'b1;
      tick(7);
      tests++; if (a_peatonal !== 1'b1) begin fails++; $display("FAIL b2b_assert s%0d: got %b expected 1", s, a_peatonal); end
      semaforo_a = L_ROJO;
      tick(1);
      tests++; if (a_peatonal !== 1'b0) begin fails++; $display("FAIL b2b_serve s%0d: got %b expected 0", s, a_peatonal); end
      btn_a = 1'b0; semaforo_a = L_VERDE;
      tick(8);
    end
`ifdef BOTON_PEATONAL_CONTADOR_EN
    tests++; if (cnt_a !== 2'd1) begin fails++; $display("FAIL b2b_wrap: got %0d expected 1", cnt_a); end
`endif
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_service;
    test_illegal_light;
    test_bounce;
    test_channel_b;
    test_simultaneous_reset;
    test_enb_freeze;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
